// File: rtl/pipelined_adder_if.sv
// Handshake bundle for pipelined_adder: operand beat upstream, result beat downstream.
// The adder takes the slave modport; the producer/consumer side takes master.
interface pipelined_adder_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder: one CW-bit chunk per stage, carry registered between stages.
// Define PIPELINED_ADDER_SAT_EN to clamp signed-overflowing results in the final stage.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    pipelined_adder_if.slave bus
);
    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic adv;
    logic out_valid;

    assign adv          = bus.out_ready | ~out_valid;
    assign bus.in_ready = adv;

    // Each stage carries only the operand bits later stages still need; the last keeps the MSBs.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IW = WIDTH - k * CW;
        localparam int HW = (k < STAGES - 1) ? IW - CW : 1;
        localparam int SW = (k + 1) * CW;

        logic [IW-1:0] op_a;
        logic [IW-1:0] op_b;
        logic          c_in;
        logic          v_in;
        logic [CW:0]   chunk;

        logic [HW-1:0] a_d, a_q;
        logic [HW-1:0] b_d, b_q;
        logic [SW-1:0] sum_d, sum_q;
        logic          carry_d, carry_q;
        logic          valid_d, valid_q;

        if (k == 0) begin : g_head
            assign op_a = bus.a;
            assign op_b = bus.b;
            assign c_in = bus.cin;
            assign v_in = bus.in_valid;

            always_comb begin
                sum_d = chunk[CW-1:0];
            end
        end else begin : g_body
            assign op_a = g_stage[k-1].a_q;
            assign op_b = g_stage[k-1].b_q;
            assign c_in = g_stage[k-1].carry_q;
            assign v_in = g_stage[k-1].valid_q;

            always_comb begin
                sum_d = {chunk[CW-1:0], g_stage[k-1].sum_q};
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            always_comb begin
                a_d = op_a[IW-1:CW];
                b_d = op_b[IW-1:CW];
            end
        end else begin : g_msb
            always_comb begin
                a_d = op_a[IW-1];
                b_d = op_b[IW-1];
            end
        end

        always_comb begin
            chunk   = {1'b0, op_a[CW-1:0]} + {1'b0, op_b[CW-1:0]} + {{CW{1'b0}}, c_in};
            carry_d = chunk[CW];
            valid_d = v_in;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                a_q     <= '0;
                b_q     <= '0;
                sum_q   <= '0;
                carry_q <= 1'b0;
                valid_q <= 1'b0;
            end else if (adv) begin
                a_q     <= a_d;
                b_q     <= b_d;
                sum_q   <= sum_d;
                carry_q <= carry_d;
                valid_q <= valid_d;
            end
        end
    end

    logic [WIDTH-1:0] raw_sum;
    logic [WIDTH-1:0] res_sum;
    logic             a_msb;
    logic             b_msb;
    logic             ovf;

    assign out_valid = g_stage[LAST].valid_q;
    assign raw_sum   = g_stage[LAST].sum_q;
    assign a_msb     = g_stage[LAST].a_q[0];
    assign b_msb     = g_stage[LAST].b_q[0];
    assign ovf       = (a_msb == b_msb) & (raw_sum[WIDTH-1] != a_msb);

`ifdef PIPELINED_ADDER_SAT_EN
    // Clamp toward the sign of the operands; cout/ovf keep reporting the raw result.
    always_comb begin
        res_sum = raw_sum;
        if (ovf) begin
            res_sum = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    always_comb begin
        res_sum = raw_sum;
    end
`endif

    assign bus.out_valid = out_valid;
    assign bus.sum       = res_sum;
    assign bus.cout      = g_stage[LAST].carry_q;
    assign bus.ovf       = ovf;
endmodule
